paddle_collide: RTL and testbench

Sequential, parametrised collision detector for the four-player pong field. It accepts a ball position and four paddle positions on a request strobe. It then scans the four sides one per cycle and reports a registered 4-bit per-side hit vector, plus the side and offset of the first hit for deflection logic. It sits between the ball-motion block and the score/deflection logic, and replaces the fixed 16×16, single-cycle candidate finder.

---
 rtl/pong_pkg.sv | 20 ++
 rtl/paddle_hit_check.sv | 64 ++++++
 rtl/paddle_collide.sv | 158 +++++++++++++++
 tb/tb_paddle_collide.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and default sizes for the four-player pong collision logic.
package pong_pkg;

  localparam int DEFAULT_GRID       = 16;
  localparam int DEFAULT_PADDLE_LEN = 4;

  typedef enum logic [1:0] {
    SIDE_LEFT  = 2'd0,
    SIDE_RIGHT = 2'd1,
    SIDE_TOP   = 2'd2,
    SIDE_DOWN  = 2'd3
  } side_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/paddle_hit_check.sv
// Combinational hit test of the ball against one paddle wall.
// PADDLE_EDGE_EN widens the window by one cell at each end of the paddle.
module paddle_hit_check
  import pong_pkg::*;
#(
  parameter int GRID       = DEFAULT_GRID,
  parameter int PADDLE_LEN = DEFAULT_PADDLE_LEN,
  parameter int COORD_W    = $clog2(GRID)
) (
  input  side_e              side,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] start,
  output logic               hit,
  output logic [COORD_W-1:0] offset
);

  localparam int EW = COORD_W + 1;
  localparam logic [EW-1:0]      LEN_E   = EW'(PADDLE_LEN);
  localparam logic [EW-1:0]      LAST_E  = EW'(GRID - 1);
  localparam logic [COORD_W-1:0] NEAR_LO = COORD_W'(1);
  localparam logic [COORD_W-1:0] NEAR_HI = COORD_W'(GRID - 2);

  logic               candidate;
  logic [COORD_W-1:0] along;
  logic [EW-1:0]      along_e;
  logic [EW-1:0]      start_e;
  logic [EW-1:0]      lo_e;
  logic [EW-1:0]      hi_e;

  always_comb begin
    candidate = 1'b0;
    along     = ball_y;
    case (side)
      SIDE_LEFT:  begin candidate = (ball_x == NEAR_LO); along = ball_y; end
      SIDE_RIGHT: begin candidate = (ball_x == NEAR_HI); along = ball_y; end
      SIDE_TOP:   begin candidate = (ball_y == NEAR_LO); along = ball_x; end
      SIDE_DOWN:  begin candidate = (ball_y == NEAR_HI); along = ball_x; end
      default:    begin candidate = 1'b0;                along = ball_y; end
    endcase

    // Extra bit keeps start+PADDLE_LEN from wrapping back into the field.
    along_e = {1'b0, along};
    start_e = {1'b0, start};
`ifdef PADDLE_EDGE_EN
    lo_e   = (start == '0) ? '0 : start_e - EW'(1);
    hi_e   = start_e + LEN_E;
    offset = along - start + COORD_W'(1);
`else
    lo_e   = start_e;
    hi_e   = start_e + LEN_E - EW'(1);
    offset = along - start;
`endif
    if (hi_e > LAST_E) begin
      hi_e = LAST_E;
    end

    hit = candidate && (along_e >= lo_e) && (along_e <= hi_e);
    if (!hit) begin
      offset = '0;
    end
  end

endmodule

// File: rtl/paddle_collide.sv
// Sequential four-side collision detector: latches a request, scans one side per cycle, reports hits.
// PADDLE_EDGE_EN (passed through to paddle_hit_check) selects the widened hit window.
module paddle_collide
  import pong_pkg::*;
#(
  parameter int GRID       = DEFAULT_GRID,
  parameter int PADDLE_LEN = DEFAULT_PADDLE_LEN,
  parameter int COORD_W    = $clog2(GRID)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [COORD_W-1:0] player_pos_left,
  input  logic [COORD_W-1:0] player_pos_right,
  input  logic [COORD_W-1:0] player_pos_top,
  input  logic [COORD_W-1:0] player_pos_down,
  output logic               busy,
  output logic               valid,
  output logic [3:0]         collide,
  output logic [1:0]         hit_side,
  output logic [COORD_W-1:0] hit_offset
);

  state_e             state_q, state_d;
  side_e              side_q, side_d;
  logic [COORD_W-1:0] ball_x_q, ball_x_d;
  logic [COORD_W-1:0] ball_y_q, ball_y_d;
  logic [COORD_W-1:0] pad_q [4];
  logic [COORD_W-1:0] pad_d [4];
  logic [3:0]         scratch_q, scratch_d;
  logic               found_q, found_d;
  side_e              first_side_q, first_side_d;
  logic [COORD_W-1:0] first_off_q, first_off_d;
  logic [3:0]         collide_q, collide_d;
  side_e              hit_side_q, hit_side_d;
  logic [COORD_W-1:0] hit_offset_q, hit_offset_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic               chk_hit;
  logic [COORD_W-1:0] chk_off;

  paddle_hit_check #(
    .GRID       (GRID),
    .PADDLE_LEN (PADDLE_LEN),
    .COORD_W    (COORD_W)
  ) u_check (
    .side   (side_q),
    .ball_x (ball_x_q),
    .ball_y (ball_y_q),
    .start  (pad_q[side_q]),
    .hit    (chk_hit),
    .offset (chk_off)
  );

  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    pad_d        = pad_q;
    scratch_d    = scratch_q;
    found_d      = found_q;
    first_side_d = first_side_q;
    first_off_d  = first_off_q;
    collide_d    = collide_q;
    hit_side_d   = hit_side_q;
    hit_offset_d = hit_offset_q;
    valid_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          ball_x_d     = pos_x;
          ball_y_d     = pos_y;
          pad_d[0]     = player_pos_left;
          pad_d[1]     = player_pos_right;
          pad_d[2]     = player_pos_top;
          pad_d[3]     = player_pos_down;
          scratch_d    = '0;
          found_d      = 1'b0;
          first_side_d = SIDE_LEFT;
          first_off_d  = '0;
          side_d       = SIDE_LEFT;
          state_d      = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scratch_d[side_q] = chk_hit;
        // Only the first side that hits supplies the deflection data.
        if (chk_hit && !found_q) begin
          found_d      = 1'b1;
          first_side_d = side_q;
          first_off_d  = chk_off;
        end
        if (side_q == SIDE_DOWN) begin
          state_d = ST_DONE;
        end else begin
          side_d = side_e'(side_q + 2'd1);
        end
      end
      ST_DONE: begin
        collide_d    = scratch_q;
        hit_side_d   = first_side_q;
        hit_offset_d = first_off_q;
        valid_d      = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // busy covers the whole transaction, including the result cycle.
    busy_d = (state_d != ST_IDLE) || valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      side_q       <= SIDE_LEFT;
      ball_x_q     <= '0;
      ball_y_q     <= '0;
      pad_q        <= '{default: '0};
      scratch_q    <= '0;
      found_q      <= 1'b0;
      first_side_q <= SIDE_LEFT;
      first_off_q  <= '0;
      collide_q    <= '0;
      hit_side_q   <= SIDE_LEFT;
      hit_offset_q <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      side_q       <= side_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      pad_q        <= pad_d;
      scratch_q    <= scratch_d;
      found_q      <= found_d;
      first_side_q <= first_side_d;
      first_off_q  <= first_off_d;
      collide_q    <= collide_d;
      hit_side_q   <= hit_side_d;
      hit_offset_q <= hit_offset_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign collide    = collide_q;
  assign hit_side   = hit_side_q;
  assign hit_offset = hit_offset_q;

endmodule

// File: tb/tb_paddle_collide.sv
// Self-checking bench for paddle_collide: directed cases plus randomized requests against a reference model.
module tb_paddle_collide;

  localparam int GRID       = 16;
  localparam int PADDLE_LEN = 4;
  localparam int COORD_W    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               req;
  logic [COORD_W-1:0] pos_x, pos_y;
  logic [COORD_W-1:0] player_pos_left, player_pos_right, player_pos_top, player_pos_down;
  logic               busy, valid;
  logic [3:0]         collide;
  logic [1:0]         hit_side;
  logic [COORD_W-1:0] hit_offset;

  int compared   = 0;
  int mismatched = 0;

  paddle_collide #(
    .GRID       (GRID),
    .PADDLE_LEN (PADDLE_LEN),
    .COORD_W    (COORD_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .pos_x            (pos_x),
    .pos_y            (pos_y),
    .player_pos_left  (player_pos_left),
    .player_pos_right (player_pos_right),
    .player_pos_top   (player_pos_top),
    .player_pos_down  (player_pos_down),
    .busy             (busy),
    .valid            (valid),
    .collide          (collide),
    .hit_side         (hit_side),
    .hit_offset       (hit_offset)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: evaluate each side straight from the wall/window rules, first hit wins.
  function automatic void refModel(input int bx, input int by, input int pads[4],
                                   output logic [3:0] expCol, output int expSide, output int expOff);
    bit found;
    found   = 1'b0;
    expCol  = 4'b0;
    expSide = 0;
    expOff  = 0;
    for (int s = 0; s < 4; s++) begin
      int along, lo, hi, off;
      bit isCand;
      case (s)
        0:       isCand = (bx == 1);
        1:       isCand = (bx == GRID - 2);
        2:       isCand = (by == 1);
        default: isCand = (by == GRID - 2);
      endcase
      along = (s < 2) ? by : bx;
`ifdef PADDLE_EDGE_EN
      lo  = (pads[s] > 0) ? pads[s] - 1 : 0;
      hi  = pads[s] + PADDLE_LEN;
      off = along - (pads[s] - 1);
`else
      lo  = pads[s];
      hi  = pads[s] + PADDLE_LEN - 1;
      off = along - pads[s];
`endif
      if (hi > GRID - 1) hi = GRID - 1;
      if (isCand && along >= lo && along <= hi) begin
        expCol[s] = 1'b1;
        if (!found) begin
          found   = 1'b1;
          expSide = s;
          expOff  = off;
        end
      end
    end
  endfunction

  task automatic driveInputs(input int bx, input int by, input int l, input int r, input int t, input int d);
    pos_x            = COORD_W'(bx);
    pos_y            = COORD_W'(by);
    player_pos_left  = COORD_W'(l);
    player_pos_right = COORD_W'(r);
    player_pos_top   = COORD_W'(t);
    player_pos_down  = COORD_W'(d);
  endtask

  // One full transaction: request, scramble inputs after latching, check timing and result.
  task automatic applyStimulus(input string name, input int bx, input int by,
                               input int l, input int r, input int t, input int d);
    int pads[4];
    logic [3:0] eCol;
    int eSide, eOff;
    bit early;
    pads = '{l, r, t, d};
    refModel(bx, by, pads, eCol, eSide, eOff);
    @(negedge clk);
    driveInputs(bx, by, l, r, t, d);
    req = 1'b1;
    @(posedge clk); #1;
    checkOutput({name, "_busy_start"}, 32'(busy), 32'd1);
    req = 1'b0;
    driveInputs(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    early = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (valid) early = 1'b1;
    end
    checkOutput({name, "_valid_early"}, 32'(early), 32'd0);
    @(posedge clk); #1;
    checkOutput({name, "_valid"},   32'(valid),      32'd1);
    checkOutput({name, "_collide"}, 32'(collide),    32'(eCol));
    checkOutput({name, "_side"},    32'(hit_side),   32'(eSide));
    checkOutput({name, "_offset"},  32'(hit_offset), 32'(eOff));
    checkOutput({name, "_busy_k5"}, 32'(busy),       32'd1);
    @(posedge clk); #1;
    checkOutput({name, "_valid_end"}, 32'(valid),   32'd0);
    checkOutput({name, "_busy_end"},  32'(busy),    32'd0);
    checkOutput({name, "_hold"},      32'(collide), 32'(eCol));
  endtask

  task automatic expectNoValid(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (valid) seen = 1'b1;
    end
    checkOutput(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int pads[4];
    logic [3:0] eCol;
    int eSide, eOff;
    int mask;

    rst = 1'b1;
    req = 1'b0;
    driveInputs(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy",    32'(busy),       32'd0);
    checkOutput("reset_valid",   32'(valid),      32'd0);
    checkOutput("reset_collide", 32'(collide),    32'd0);
    checkOutput("reset_side",    32'(hit_side),   32'd0);
    checkOutput("reset_offset",  32'(hit_offset), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("left_hit", 1, 7, 5, 0, 0, 0);
    checkOutput("left_hit_literal", 32'({collide, hit_side, hit_offset}), 32'({4'b0001, 2'd0, 4'd2}));
    applyStimulus("corner",    1, 1, 0, 0, 1, 0);
    applyStimulus("miss",      14, 9, 0, 10, 0, 0);
    applyStimulus("ovf_hit",   15, 14, 0, 0, 0, 14);
    applyStimulus("ovf_nowrap", 0, 14, 0, 0, 0, 14);
    applyStimulus("down_far",  15, 14, 0, 0, 0, 15);

    // Second request while busy must be ignored.
    pads = '{5, 0, 0, 0};
    refModel(1, 7, pads, eCol, eSide, eOff);
    @(negedge clk);
    driveInputs(1, 7, 5, 0, 0, 0);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    driveInputs(1, 1, 0, 0, 1, 0);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(posedge clk); #1;
    checkOutput("busyreq_valid",   32'(valid),      32'd1);
    checkOutput("busyreq_collide", 32'(collide),    32'(eCol));
    checkOutput("busyreq_offset",  32'(hit_offset), 32'(eOff));
    expectNoValid("busyreq_no_second", 8);

    // Reset mid-scan aborts the request and clears the held result.
    @(negedge clk);
    driveInputs(1, 1, 0, 0, 1, 0);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_collide", 32'(collide), 32'd0);
    checkOutput("abort_busy",    32'(busy),    32'd0);
    expectNoValid("abort_no_valid", 8);

    // rst and req together: reset wins.
    @(negedge clk);
    driveInputs(1, 7, 5, 0, 0, 0);
    rst = 1'b1;
    req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = 1'b0;
    checkOutput("rstreq_busy", 32'(busy), 32'd0);
    expectNoValid("rstreq_no_valid", 8);

    // req held high: restarts every 6 cycles.
    pads = '{5, 0, 0, 0};
    refModel(1, 7, pads, eCol, eSide, eOff);
    @(negedge clk);
    driveInputs(1, 7, 5, 0, 0, 0);
    req = 1'b1;
    @(posedge clk); #1;
    mask = 0;
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk); #1;
      if (valid) mask |= (1 << e);
      if (e == 12) req = 1'b0;
    end
    checkOutput("stream_valid_mask", 32'(mask), 32'((1 << 5) | (1 << 11)));
    checkOutput("stream_collide",    32'(collide), 32'(eCol));
    repeat (8) @(posedge clk);

    for (int i = 0; i < 60; i++) begin
      int bx, by;
      case ($urandom_range(0, 4))
        0:       begin bx = 1;  by = int'($urandom_range(0, 15)); end
        1:       begin bx = 14; by = int'($urandom_range(0, 15)); end
        2:       begin by = 1;  bx = int'($urandom_range(0, 15)); end
        3:       begin by = 14; bx = int'($urandom_range(0, 15)); end
        default: begin bx = int'($urandom_range(0, 15)); by = int'($urandom_range(0, 15)); end
      endcase
      applyStimulus("rand", bx, by, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
